// File: rtl/axis_pkt_gen_pkg.sv
// Shared types, constants and helpers for the axis_pkt_gen packet source.
// PRBS payload is selected at build time with AXIS_PKT_GEN_PRBS_EN.
package axis_pkt_gen_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_CNT_W  = 32;

  // x^31 + x^28 + 1: feedback taken from state bits 30 and 27
  localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;
  localparam logic [30:0] PRBS31_TAPS = 31'h4800_0000;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  function automatic logic [30:0] prbs31_next(input logic [30:0] cur);
    return {cur[29:0], ^(cur & PRBS31_TAPS)};
  endfunction

endpackage

// File: rtl/axis_prbs31.sv
// PRBS31 LFSR with synchronous load of the seed and per-beat stepping.
// Exposes the next state so the caller can register it alongside the data.
module axis_prbs31
  import axis_pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [30:0] state,
  output logic [30:0] next
);

  assign next = prbs31_next(state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRBS31_SEED;
    end else if (load) begin
      state <= PRBS31_SEED;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: fixed-length packets, programmable gap, finite or endless runs.
// Define AXIS_PKT_GEN_PRBS_EN for a PRBS31 payload instead of the running word counter.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              link_clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [CNT_W-1:0]  cfg_pkt_num,
  output logic [DATA_W-1:0] m_axis_link_tdata,
  output logic              m_axis_link_tlast,
  output logic              m_axis_link_tvalid,
  input  logic              m_axis_link_tready,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  word_cnt;

  logic              accept;
  logic [LEN_W-1:0]  cfg_len_eff;
  logic [LEN_W-1:0]  beat_next;
  logic [CNT_W-1:0]  word_next;
  logic [CNT_W-1:0]  pkt_next;
  logic [DATA_W-1:0] first_data;
  logic [DATA_W-1:0] step_data;

  assign accept      = m_axis_link_tvalid & m_axis_link_tready;
  assign cfg_len_eff = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
  assign beat_next   = beat_cnt + LEN_W'(1);
  assign word_next   = word_cnt + CNT_W'(1);
  assign pkt_next    = stat_pkt_cnt + CNT_W'(1);

`ifdef AXIS_PKT_GEN_PRBS_EN
  logic [30:0] prbs_state;
  logic [30:0] prbs_next;

  axis_prbs31 u_prbs (
    .clk   (link_clk),
    .rst_n (rst_n),
    .load  (state == IDLE && cfg_enable),
    .step  (state == SEND && accept),
    .state (prbs_state),
    .next  (prbs_next)
  );

  assign first_data = {(DATA_W/32){1'b0, PRBS31_SEED}};
  assign step_data  = {(DATA_W/32){1'b0, prbs_next}};
`else
  assign first_data = DATA_W'(CNT_W'(1));
  assign step_data  = DATA_W'(word_next);
`endif

  // tdata is advanced on every accepted beat, so it is already correct when SEND resumes after GAP
  always_ff @(posedge link_clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      len_q              <= LEN_W'(1);
      beat_cnt           <= '0;
      gap_q              <= '0;
      gap_cnt            <= '0;
      num_q              <= '0;
      word_cnt           <= CNT_W'(1);
      m_axis_link_tdata  <= '0;
      m_axis_link_tlast  <= 1'b0;
      m_axis_link_tvalid <= 1'b0;
      stat_pkt_cnt       <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cfg_enable) begin
            state              <= SEND;
            len_q              <= cfg_len_eff;
            gap_q              <= cfg_gap;
            num_q              <= cfg_pkt_num;
            stat_pkt_cnt       <= '0;
            word_cnt           <= CNT_W'(1);
            beat_cnt           <= '0;
            m_axis_link_tdata  <= first_data;
            m_axis_link_tlast  <= (cfg_len_eff == LEN_W'(1));
            m_axis_link_tvalid <= 1'b1;
            busy               <= 1'b1;
          end
        end

        SEND: begin
          if (accept) begin
            word_cnt          <= word_next;
            m_axis_link_tdata <= step_data;
            if (m_axis_link_tlast) begin
              stat_pkt_cnt <= pkt_next;
              beat_cnt     <= '0;
              if (num_q != '0 && pkt_next == num_q) begin
                state              <= DONE;
                m_axis_link_tvalid <= 1'b0;
                m_axis_link_tlast  <= 1'b0;
                busy               <= 1'b0;
                done               <= 1'b1;
              end else if (!cfg_enable) begin
                state              <= IDLE;
                m_axis_link_tvalid <= 1'b0;
                m_axis_link_tlast  <= 1'b0;
                busy               <= 1'b0;
              end else if (gap_q == '0) begin
                m_axis_link_tlast <= (len_q == LEN_W'(1));
              end else begin
                state              <= GAP;
                gap_cnt            <= GAP_W'(1);
                m_axis_link_tvalid <= 1'b0;
                m_axis_link_tlast  <= 1'b0;
              end
            end else begin
              beat_cnt          <= beat_next;
              m_axis_link_tlast <= (beat_next == len_q - LEN_W'(1));
            end
          end
        end

        GAP: begin
          if (gap_cnt == gap_q) begin
            if (cfg_enable) begin
              state              <= SEND;
              m_axis_link_tvalid <= 1'b1;
              m_axis_link_tlast  <= (len_q == LEN_W'(1));
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        DONE: begin
          if (!cfg_enable) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: randomized backpressure against a packet-level reference model.
// Define AXIS_PKT_GEN_PRBS_EN to also check the PRBS payload.
module tb_axis_pkt_gen;

  logic         link_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_enable = 1'b0;
  logic [15:0]  cfg_pkt_len = '0;
  logic [7:0]   cfg_gap = '0;
  logic [31:0]  cfg_pkt_num = '0;
  logic [127:0] m_axis_link_tdata;
  logic         m_axis_link_tlast;
  logic         m_axis_link_tvalid;
  logic         m_axis_link_tready = 1'b1;
  logic [31:0]  stat_pkt_cnt;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass = 0;
  int hold_errs = 0;
  int cyc = 0;

  logic [127:0] q_data[$];
  logic         q_last[$];
  int           q_cyc[$];

  axis_pkt_gen dut (
    .link_clk           (link_clk),
    .rst_n              (rst_n),
    .cfg_enable         (cfg_enable),
    .cfg_pkt_len        (cfg_pkt_len),
    .cfg_gap            (cfg_gap),
    .cfg_pkt_num        (cfg_pkt_num),
    .m_axis_link_tdata  (m_axis_link_tdata),
    .m_axis_link_tlast  (m_axis_link_tlast),
    .m_axis_link_tvalid (m_axis_link_tvalid),
    .m_axis_link_tready (m_axis_link_tready),
    .stat_pkt_cnt       (stat_pkt_cnt),
    .busy               (busy),
    .done               (done)
  );

  always #5 link_clk = ~link_clk;
  always @(posedge link_clk) cyc <= cyc + 1;

  // Expected payload of the n-th word of a run (n starts at 1)
  function automatic logic [127:0] exp_data(input int unsigned n);
`ifdef AXIS_PKT_GEN_PRBS_EN
    logic [30:0] s;
    s = 31'h7FFF_FFFF;
    for (int unsigned i = 1; i < n; i++) s = {s[29:0], s[30] ^ s[27]};
    return {4{1'b0, s}};
`else
    return 128'(n);
`endif
  endfunction

  // Records accepted beats (sampled 1 time unit after the falling edge) and counts stall-hold violations
  task automatic collect(input int n, input int budget, input bit rand_ready, output int timed_out);
    bit           prev_stall;
    logic [127:0] prev_d;
    logic         prev_l;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    for (int c = 0; c < budget && q_data.size() < n; c++) begin
      @(negedge link_clk);
      m_axis_link_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && (!m_axis_link_tvalid || m_axis_link_tdata !== prev_d ||
                         m_axis_link_tlast !== prev_l))
        hold_errs++;
      prev_stall = m_axis_link_tvalid && !m_axis_link_tready;
      prev_d = m_axis_link_tdata;
      prev_l = m_axis_link_tlast;
      if (m_axis_link_tvalid && m_axis_link_tready) begin
        q_data.push_back(m_axis_link_tdata);
        q_last.push_back(m_axis_link_tlast);
        q_cyc.push_back(cyc);
      end
    end
    timed_out = (q_data.size() < n) ? 1 : 0;
  endtask

  task automatic start_run(input logic [15:0] len, input logic [7:0] gap, input logic [31:0] num);
    @(negedge link_clk);
    cfg_pkt_len = len;
    cfg_gap = gap;
    cfg_pkt_num = num;
    cfg_enable = 1'b1;
    hold_errs = 0;
  endtask

  task automatic stop_run(input string name);
    int c;
    @(negedge link_clk);
    cfg_enable = 1'b0;
    m_axis_link_tready = 1'b1;
    c = 0;
    while ((busy || done) && c < 300) begin
      @(negedge link_clk);
      c++;
    end
    n_checks++;
    if (busy || done)
      $display("[TB] FAIL %s_stop: busy=%0b done=%0b, required 0/0 within 300 cycles", name, busy, done);
    else n_pass++;
  endtask

  // Checks the collected beats against packets of len beats numbered from first_word
  task automatic check_beats(input string name, input int len, input int first_word);
    for (int i = 0; i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_data(first_word + i))
        $display("[TB] FAIL %s_data[%0d]: got %h required %h", name, i, q_data[i], exp_data(first_word + i));
      else n_pass++;
      n_checks++;
      if (q_last[i] !== (((first_word + i - 1) % len) == len - 1))
        $display("[TB] FAIL %s_last[%0d]: got %0b required %0b", name, i, q_last[i],
                 (((first_word + i - 1) % len) == len - 1));
      else n_pass++;
    end
  endtask

  task automatic check_timeout(input string name, input int to, input int required);
    n_checks++;
    if (to !== required) $display("[TB] FAIL %s_timeout: got %0d required %0d", name, to, required);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge link_clk);
    #1;
    n_checks += 6;
    if (m_axis_link_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %0b required 0", m_axis_link_tvalid); else n_pass++;
    if (m_axis_link_tlast !== 1'b0) $display("[TB] FAIL reset_tlast: got %0b required 0", m_axis_link_tlast); else n_pass++;
    if (m_axis_link_tdata !== '0) $display("[TB] FAIL reset_tdata: got %h required 0", m_axis_link_tdata); else n_pass++;
    if (stat_pkt_cnt !== '0) $display("[TB] FAIL reset_stat: got %0d required 0", stat_pkt_cnt); else n_pass++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b required 0", busy); else n_pass++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b required 0", done); else n_pass++;
    @(negedge link_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    int to;
    start_run(16'd4, 8'd0, 32'd2);
    collect(8, 100, 1'b0, to);
    check_timeout("burst", to, 0);
    check_beats("burst", 4, 1);
    n_checks++;
    if (q_cyc.size() == 8 && q_cyc[7] - q_cyc[0] == 7) n_pass++;
    else $display("[TB] FAIL burst_back_to_back: beats spread over %0d cycles, required 7",
                  q_cyc.size() == 8 ? q_cyc[7] - q_cyc[0] : -1);
    repeat (3) @(negedge link_clk);
    #1;
    n_checks += 3;
    if (done !== 1'b1) $display("[TB] FAIL burst_done: got %0b required 1", done); else n_pass++;
    if (stat_pkt_cnt !== 32'd2) $display("[TB] FAIL burst_stat: got %0d required 2", stat_pkt_cnt); else n_pass++;
    if (m_axis_link_tvalid !== 1'b0) $display("[TB] FAIL burst_idle_valid: got %0b required 0", m_axis_link_tvalid); else n_pass++;
    stop_run("burst");
  endtask

  task automatic test_gap();
    int to;
    start_run(16'd3, 8'd5, 32'd0);
    collect(7, 200, 1'b0, to);
    check_timeout("gap", to, 0);
    check_beats("gap", 3, 1);
    n_checks += 2;
    if (q_cyc.size() == 7 && q_cyc[3] - q_cyc[2] == 6) n_pass++;
    else $display("[TB] FAIL gap_len1: spacing %0d cycles, required 6", q_cyc.size() == 7 ? q_cyc[3] - q_cyc[2] : -1);
    if (q_cyc.size() == 7 && q_cyc[6] - q_cyc[5] == 6) n_pass++;
    else $display("[TB] FAIL gap_len2: spacing %0d cycles, required 6", q_cyc.size() == 7 ? q_cyc[6] - q_cyc[5] : -1);
    cfg_enable = 1'b0;
    collect(2, 50, 1'b0, to);
    check_timeout("gap_finish", to, 0);
    check_beats("gap_finish", 3, 8);
    collect(1, 20, 1'b0, to);
    check_timeout("gap_no_more", to, 1);
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL gap_busy_after_stop: got %0b required 0", busy); else n_pass++;
    stop_run("gap");
  endtask

  task automatic test_backpressure();
    int to;
    start_run(16'd16, 8'd2, 32'd4);
    collect(64, 2000, 1'b1, to);
    check_timeout("bp", to, 0);
    check_beats("bp", 16, 1);
    repeat (3) @(negedge link_clk);
    #1;
    n_checks += 3;
    if (hold_errs !== 0) $display("[TB] FAIL bp_hold: %0d violations, required 0", hold_errs); else n_pass++;
    if (done !== 1'b1) $display("[TB] FAIL bp_done: got %0b required 1", done); else n_pass++;
    if (stat_pkt_cnt !== 32'd4) $display("[TB] FAIL bp_stat: got %0d required 4", stat_pkt_cnt); else n_pass++;
    stop_run("bp");
  endtask

  task automatic test_random_runs();
    int to, len, gap, num;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      num = $urandom_range(1, 3);
      start_run(16'(len), 8'(gap), 32'(num));
      collect(len * num, 1000, 1'b1, to);
      check_timeout("rand", to, 0);
      check_beats("rand", len, 1);
      repeat (3) @(negedge link_clk);
      #1;
      n_checks += 3;
      if (hold_errs !== 0) $display("[TB] FAIL rand_hold: %0d violations, required 0", hold_errs); else n_pass++;
      if (done !== 1'b1) $display("[TB] FAIL rand_done: got %0b required 1", done); else n_pass++;
      if (stat_pkt_cnt !== 32'(num)) $display("[TB] FAIL rand_stat: got %0d required %0d", stat_pkt_cnt, num); else n_pass++;
      stop_run("rand");
    end
  endtask

  task automatic test_len_zero();
    int to;
    start_run(16'd0, 8'd1, 32'd3);
    collect(1, 50, 1'b0, to);
    cfg_pkt_len = 16'd5;
    check_beats("len0_a", 1, 1);
    collect(2, 50, 1'b0, to);
    check_timeout("len0", to, 0);
    check_beats("len0_b", 1, 2);
    repeat (3) @(negedge link_clk);
    #1;
    n_checks += 2;
    if (done !== 1'b1) $display("[TB] FAIL len0_done: got %0b required 1", done); else n_pass++;
    if (stat_pkt_cnt !== 32'd3) $display("[TB] FAIL len0_stat: got %0d required 3", stat_pkt_cnt); else n_pass++;
    stop_run("len0");
  endtask

  task automatic test_mid_reset();
    int to;
    start_run(16'd4, 8'd0, 32'd0);
    collect(2, 50, 1'b0, to);
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (m_axis_link_tvalid !== 1'b0) $display("[TB] FAIL mrst_tvalid: got %0b required 0", m_axis_link_tvalid); else n_pass++;
    if (m_axis_link_tlast !== 1'b0) $display("[TB] FAIL mrst_tlast: got %0b required 0", m_axis_link_tlast); else n_pass++;
    if (m_axis_link_tdata !== '0) $display("[TB] FAIL mrst_tdata: got %h required 0", m_axis_link_tdata); else n_pass++;
    repeat (2) @(negedge link_clk);
    rst_n = 1'b1;
    collect(1, 50, 1'b0, to);
    check_timeout("mrst", to, 0);
    check_beats("mrst", 4, 1);
    stop_run("mrst");
  endtask

`ifdef AXIS_PKT_GEN_PRBS_EN
  task automatic test_prbs();
    int to;
    logic [30:0] s2;
    s2 = {31'h7FFF_FFFF} << 1;
    s2[0] = 1'b0;
    start_run(16'd2, 8'd0, 32'd1);
    collect(2, 50, 1'b0, to);
    check_timeout("prbs", to, 0);
    for (int lane = 0; lane < 4; lane++) begin
      n_checks += 2;
      if (q_data.size() == 2 && q_data[0][lane*32 +: 32] === {1'b0, 31'h7FFF_FFFF}) n_pass++;
      else $display("[TB] FAIL prbs_beat1_lane%0d: got %h required %h", lane,
                    q_data.size() > 0 ? q_data[0][lane*32 +: 32] : 32'hx, {1'b0, 31'h7FFF_FFFF});
      if (q_data.size() == 2 && q_data[1][lane*32 +: 32] === {1'b0, s2}) n_pass++;
      else $display("[TB] FAIL prbs_beat2_lane%0d: got %h required %h", lane,
                    q_data.size() > 1 ? q_data[1][lane*32 +: 32] : 32'hx, {1'b0, s2});
    end
    stop_run("prbs");
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_gap();
    test_backpressure();
    test_random_runs();
    test_len_zero();
    test_mid_reset();
`ifdef AXIS_PKT_GEN_PRBS_EN
    test_prbs();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
